// File: rtl/bubble_sort_pkg.sv
// rtl/bubble_sort_pkg.sv - shared state type and compare helper for the bubble sort controller
package bubble_sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPARE,
    WRITE_A,
    WRITE_B,
    DONE
  } bs_state_t;

  // Operands are extended to this width by the caller (sign- or zero-extended)
  localparam int GT_WIDTH = 64;

  function automatic logic gt(input logic [GT_WIDTH-1:0] a,
                              input logic [GT_WIDTH-1:0] b,
                              input logic is_signed);
    if (is_signed) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// rtl/bubble_sort_ctrl_if.sv - parent handshake and memory bus of the bubble sort controller
interface bubble_sort_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
);
  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  swap_count;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Parent / memory side
  modport master (
    output start, len, mem_rdata,
    input  busy, done, swap_count, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Controller side
  modport slave (
    input  start, len, mem_rdata,
    output busy, done, swap_count, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// rtl/bubble_sort_ctrl.sv - in-place ascending bubble sort of one memory block with early exit
module bubble_sort_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int SIGNED     = 0,
  parameter int CNT_WIDTH  = 32
) (
  input logic clk,
  input logic rst,
  bubble_sort_ctrl_if.slave bus
);
  import bubble_sort_pkg::*;

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] DEPTH_N = IW'(DEPTH);
  localparam logic [IW-1:0] ONE_N   = IW'(1);

  bs_state_t state, next_state;

  logic [IW-1:0]         i, limit, n, i_plus1;
  logic [DATA_WIDTH-1:0] reg_a, reg_b;
  logic                  swapped;
  logic [CNT_WIDTH-1:0]  swap_cnt;
  logic [GT_WIDTH-1:0]   a_ext, b_ext;
  logic                  a_gt_b, more_in_pass, finish_run, do_step;

  assign n       = (bus.len > DEPTH_N) ? DEPTH_N : bus.len;
  assign i_plus1 = i + ONE_N;

  assign a_ext  = (SIGNED != 0) ? GT_WIDTH'($signed(reg_a)) : GT_WIDTH'(reg_a);
  assign b_ext  = (SIGNED != 0) ? GT_WIDTH'($signed(reg_b)) : GT_WIDTH'(reg_b);
  assign a_gt_b = gt(a_ext, b_ext, SIGNED != 0);

  // Pass-step decision shared by COMPARE (no swap) and WRITE_B
  assign more_in_pass = i_plus1 < limit;
  assign finish_run   = !swapped || (limit == ONE_N);
  assign do_step      = ((state == COMPARE) && !a_gt_b) || (state == WRITE_B);

  assign bus.swap_count = swap_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and memory/handshake outputs decoded from the current state
  always_comb begin
    next_state    = state;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = (n <= ONE_N) ? DONE : LOAD_A;
      end
      LOAD_A: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = i[ADDR_WIDTH-1:0];
        next_state   = LOAD_B;
      end
      LOAD_B: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = i_plus1[ADDR_WIDTH-1:0];
        next_state   = COMPARE;
      end
      COMPARE: begin
        if (a_gt_b)                          next_state = WRITE_A;
        else if (!more_in_pass && finish_run) next_state = DONE;
        else                                 next_state = LOAD_A;
      end
      WRITE_A: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = i[ADDR_WIDTH-1:0];
        bus.mem_wdata = reg_b;
        next_state    = WRITE_B;
      end
      WRITE_B: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = i_plus1[ADDR_WIDTH-1:0];
        bus.mem_wdata = reg_a;
        next_state    = (!more_in_pass && finish_run) ? DONE : LOAD_A;
      end
      DONE: begin
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: pass index, pass limit, operand latches, swap tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i        <= '0;
      limit    <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      swapped  <= 1'b0;
      swap_cnt <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        swap_cnt <= '0;
        i        <= '0;
        limit    <= (n > ONE_N) ? n - ONE_N : '0;
        swapped  <= 1'b0;
      end
      if (state == LOAD_A) reg_a <= bus.mem_rdata;
      if (state == LOAD_B) reg_b <= bus.mem_rdata;
      if (state == COMPARE && a_gt_b) swapped <= 1'b1;
      if (state == WRITE_B && swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
      if (do_step) begin
        if (more_in_pass) begin
          i <= i_plus1;
        end else if (!finish_run) begin
          limit   <= limit - ONE_N;
          i       <= '0;
          swapped <= 1'b0;
        end
      end
    end
  end

endmodule
